// File: rtl/qei_gen_if.sv
// Command channel for qei_gen: valid/ready handshake carrying direction,
// step count and step interval.
interface qei_gen_if #(
    parameter int PERIOD_W = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_dir;
    logic [15:0]         cmd_steps;
    logic [PERIOD_W-1:0] cmd_period;

    modport master (output cmd_valid, cmd_dir, cmd_steps, cmd_period, input cmd_ready);
    modport slave  (input cmd_valid, cmd_dir, cmd_steps, cmd_period, output cmd_ready);
endinterface

// File: rtl/qei_gen.sv
// Quadrature encoder signal generator: turns step commands into Gray-coded A/B
// outputs at a programmable rate. Optional index output under QEI_GEN_INDEX_EN.
module qei_gen #(
    parameter int PERIOD_W = 8,
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    qei_gen_if.slave    cmd,
    output logic        qa,
    output logic        qb,
    output logic        idx,
    output logic        busy,
    output logic        done,
    output logic [15:0] position
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                dir_q, dir_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [15:0]         pos_q, pos_d;
    logic                qa_q, qb_q;
    logic                done_q, done_d;
    logic                accept_s;

    if (IDX_BITS < 2) begin : g_idx_check
        $error("qei_gen: IDX_BITS must be at least 2");
    end

    assign accept_s      = cmd.cmd_valid && (state_q == ST_IDLE);
    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q == ST_RUN);
    assign done          = done_q;
    assign qa            = qa_q;
    assign qb            = qb_q;
    assign position      = pos_q;

    // Next-state logic for the command sequencer and step timer.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        remaining_d = remaining_q;
        period_d    = period_q;
        timer_d     = timer_q;
        pos_d       = pos_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    dir_d       = cmd.cmd_dir;
                    remaining_d = cmd.cmd_steps;
                    period_d    = cmd.cmd_period;
                    // First step is taken on the first RUN cycle; the interval
                    // only separates consecutive steps.
                    timer_d     = {PERIOD_W{1'b0}};
                    if (cmd.cmd_steps != 16'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (timer_q != {PERIOD_W{1'b0}}) begin
                    timer_d = timer_q - {{(PERIOD_W-1){1'b0}}, 1'b1};
                end else begin
                    pos_d       = dir_q ? (pos_q + 16'd1) : (pos_q - 16'd1);
                    timer_d     = period_q;
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; A/B are the Gray code of the low position bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            remaining_q <= 16'd0;
            period_q    <= {PERIOD_W{1'b0}};
            timer_q     <= {PERIOD_W{1'b0}};
            pos_q       <= 16'd0;
            qa_q        <= 1'b0;
            qb_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            remaining_q <= remaining_d;
            period_q    <= period_d;
            timer_q     <= timer_d;
            pos_q       <= pos_d;
            qa_q        <= pos_d[1];
            qb_q        <= pos_d[1] ^ pos_d[0];
            done_q      <= done_d;
        end
    end

`ifdef QEI_GEN_INDEX_EN
    logic idx_q;

    // Index marks every position whose low IDX_BITS bits are zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 1'b1;
        end else begin
            idx_q <= (pos_d[IDX_BITS-1:0] == {IDX_BITS{1'b0}});
        end
    end

    assign idx = idx_q;
`else
    assign idx = 1'b0;
`endif

endmodule
